// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths: frame FSM
// states, default frame/FIFO parameters and the baud divisor helper.
package uart_pkg;

    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 19200;

    // Rounded clocks per oversampling tick.
    function automatic int baud_dvsr(input int clk_hz, input int baud_rate, input int oversample);
        return (clk_hz + (baud_rate * oversample) / 2) / (baud_rate * oversample);
    endfunction

    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;
    localparam int DVSR_DEF    = baud_dvsr(CLK_FREQ, BAUD, SB_TICK_DEF);
    localparam int FIFO_W_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_tx_unit_if.sv
// Byte write port of the UART transmitter plus its status flags and FSM state.
// wr is a one-cycle strobe: a byte is accepted on every clock where wr=1 and
// tx_full=0, and silently dropped when tx_full=1; there is no other handshake.
interface uart_tx_unit_if #(
    parameter int DBIT = 8
);
    import uart_pkg::*;

    logic            wr;
    logic [DBIT-1:0] w_data;
    logic            tx_full;
    logic            tx_empty;
    logic            tx_busy;
    state_t          dbg_state;

    modport master (output wr, w_data, input tx_full, tx_empty, tx_busy, dbg_state);
    modport slave  (input wr, w_data, output tx_full, tx_empty, tx_busy, dbg_state);

endinterface

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with registered full/empty flags; shared by the
// UART transmit and receive paths.
module uart_fifo #(
    parameter int W      = 8,
    parameter int FIFO_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] w_data,
    output logic [W-1:0] r_data,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 2 ** FIFO_W;

    logic [W-1:0]      mem_q [DEPTH];
    logic [FIFO_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              push, pop;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign push = wr && !full_q;
    assign pop  = rd && !empty_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= w_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        full_d  = full_q;
        empty_d = empty_q;
        unique case ({push, pop})
            2'b10: begin
                wptr_d  = wptr_q + 1'b1;
                empty_d = 1'b0;
                full_d  = (wptr_d == rptr_q);
            end
            2'b01: begin
                rptr_d  = rptr_q + 1'b1;
                full_d  = 1'b0;
                empty_d = (rptr_d == wptr_q);
            end
            2'b11: begin
                wptr_d = wptr_q + 1'b1;
                rptr_d = rptr_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign r_data = mem_q[rptr_q];
    assign full   = full_q;
    assign empty  = empty_q;

endmodule

// File: rtl/uart_tx_unit.sv
// UART 8N1 transmitter: byte FIFO feeding a serializer timed by an internal
// oversampling tick generator. The serial pin is driven from a flop.
module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int DVSR    = DVSR_DEF,
    parameter int FIFO_W  = FIFO_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_unit_if.slave bus,
    output logic          tx
);
    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int SW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            tick, pop, last_tick;
    logic            fifo_full, fifo_empty;
    logic [DBIT-1:0] fifo_rdata;

    uart_fifo #(.W(DBIT), .FIFO_W(FIFO_W)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (bus.wr),
        .rd     (pop),
        .w_data (bus.w_data),
        .r_data (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign tick      = (cnt_q == CW'(DVSR - 1));
    assign last_tick = tick && (s_q == SW'(SB_TICK - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Every state lasts SB_TICK ticks; the tick counter restarts on frame entry
    // so the start bit is full length.
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        s_d     = tick ? s_q + 1'b1 : s_q;
        n_d     = n_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                s_d = s_q;
                if (!fifo_empty) begin
                    shift_d = fifo_rdata;
                    pop     = 1'b1;
                    cnt_d   = '0;
                    s_d     = '0;
                    n_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (last_tick) begin
                    s_d     = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (last_tick) begin
                    s_d     = '0;
                    shift_d = shift_q >> 1;
                    if (n_q == NW'(DBIT - 1)) state_d = STOP;
                    else n_d = n_q + 1'b1;
                end
            end
            STOP: begin
                if (last_tick) begin
                    s_d     = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level for the next cycle, registered so the pin is glitch-free.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx            = tx_q;
    assign bus.tx_full   = fifo_full;
    assign bus.tx_empty  = fifo_empty;
    assign bus.tx_busy   = (state_q != IDLE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit, run with a short baud divisor so whole
// frames fit in a few hundred clocks.
module tb_uart_tx_unit;
    import uart_pkg::*;

    localparam int TB_DVSR = 5;
    localparam int BIT     = 16 * TB_DVSR;
    localparam int FRAME   = 10 * BIT;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] wq[$];

    uart_tx_unit_if #(.DBIT(8)) bus ();

    uart_tx_unit #(.DBIT(8), .SB_TICK(16), .DVSR(TB_DVSR), .FIFO_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_seq;  // line bits in send order, first bit leftmost
    } vec_t;

    vec_t vecs[5];

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic write_burst();
        foreach (wq[i]) begin
            bus.wr     = 1'b1;
            bus.w_data = wq[i];
            step();
        end
        bus.wr = 1'b0;
        wq.delete();
    endtask

    task automatic run_len(input logic level, output int len);
        len = 0;
        while (tx === level && len < 2 * FRAME) begin
            len++;
            step();
        end
    endtask

    task automatic wait_low(output logic found);
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Samples mid-bit; returns in the middle of the stop bit.
    task automatic get_frame(output logic [7:0] b, output logic [7:0] seq,
                             output logic got, output int fall_cyc);
        logic found, start_ok;
        b = '0; seq = '0; got = 1'b0; fall_cyc = 0;
        wait_low(found);
        if (found) begin
            fall_cyc = cyc;
            repeat (BIT / 2) step();
            start_ok = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) step();
                b[i] = tx;
                seq  = {seq[6:0], tx};
            end
            repeat (BIT) step();
            got = start_ok && (tx === 1'b1);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic expect_frames(input string tag, input int n);
        logic [7:0] b, seq, e;
        logic got;
        int fc;
        for (int k = 0; k < n; k++) begin
            get_frame(b, seq, got, fc);
            check({tag, "_framed"}, got, 1'b1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check({tag, "_byte"}, b, e);
        end
    endtask

    task automatic expect_silence(input string tag, input int cycles);
        int lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (tx !== 1'b1) lows++;
            step();
        end
        check(tag, lows, 0);
    endtask

    initial begin
        logic [7:0] b, seq;
        logic got, found;
        int lat, len, f0, f1;

        vecs[0] = '{data: 8'h01, exp_seq: 8'b1000_0000};
        vecs[1] = '{data: 8'hA5, exp_seq: 8'b1010_0101};
        vecs[2] = '{data: 8'h3C, exp_seq: 8'b0011_1100};
        vecs[3] = '{data: 8'hC8, exp_seq: 8'b0001_0011};
        vecs[4] = '{data: 8'h5E, exp_seq: 8'b0111_1010};

        bus.wr = 1'b0;
        bus.w_data = '0;

        // Reset state, then a quiet line.
        #100;
        check("rst_tx", tx, 1'b1);
        check("rst_empty", bus.tx_empty, 1'b1);
        check("rst_full", bus.tx_full, 1'b0);
        check("rst_busy", bus.tx_busy, 1'b0);
        check("rst_state", bus.dbg_state, IDLE);
        reset = 1'b1;
        step();
        expect_silence("idle_quiet", 10 * BIT);

        // Single byte 0x01: latency and exact bit lengths.
        bus.wr = 1'b1;
        bus.w_data = 8'h01;
        step();
        bus.wr = 1'b0;
        lat = 1;
        while (tx !== 1'b0 && lat < 20) begin
            step();
            lat++;
        end
        check("latency", lat, 2);
        run_len(1'b0, len);
        check("start_len", len, BIT);
        run_len(1'b1, len);
        check("bit0_len", len, BIT);
        run_len(1'b0, len);
        check("bits1_7_len", len, 7 * BIT);
        len = 0;
        while (bus.tx_busy === 1'b1 && tx === 1'b1 && len < 2 * FRAME) begin
            len++;
            step();
        end
        check("stop_len", len, BIT);
        check("done_busy", bus.tx_busy, 1'b0);
        check("done_empty", bus.tx_empty, 1'b1);

        // Table of single frames.
        for (int v = 0; v < 5; v++) begin
            bus.wr = 1'b1;
            bus.w_data = vecs[v].data;
            step();
            bus.wr = 1'b0;
            get_frame(b, seq, got, f0);
            check($sformatf("vec%0d_framed", v), got, 1'b1);
            check($sformatf("vec%0d_seq", v), seq, vecs[v].exp_seq);
            check($sformatf("vec%0d_byte", v), b, vecs[v].data);
            repeat (BIT) step();
            check($sformatf("vec%0d_busy", v), bus.tx_busy, 1'b0);
            check($sformatf("vec%0d_empty", v), bus.tx_empty, 1'b1);
        end

        // Back-to-back frames with a single idle clock between them.
        wq = '{8'hA5, 8'h3C};
        write_burst();
        get_frame(b, seq, got, f0);
        check("b2b0_seq", seq, 8'b1010_0101);
        get_frame(b, seq, got, f1);
        check("b2b1_seq", seq, 8'b0011_1100);
        check("b2b_period", f1 - f0, FRAME + 1);
        repeat (BIT) step();

        // Five writes fill the FIFO (one already popped); sixth is dropped.
        wq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        write_burst();
        check("five_full", bus.tx_full, 1'b1);
        bus.wr = 1'b1;
        bus.w_data = 8'h15;
        step();
        bus.wr = 1'b0;
        check("six_full", bus.tx_full, 1'b1);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        expect_frames("five", 5);
        expect_silence("five_after", 2 * FRAME);
        check("five_empty", bus.tx_empty, 1'b1);

        // Write while full in the same cycle as the FSM pops.
        wq = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
        write_burst();
        check("fp_full", bus.tx_full, 1'b1);
        exp_q = '{8'h20};
        expect_frames("fp_first", 1);
        found = 1'b0;
        for (int i = 0; i < 2 * BIT; i++) begin
            if (bus.dbg_state == IDLE) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("fp_idle_seen", found, 1'b1);
        bus.wr = 1'b1;
        bus.w_data = 8'hEE;
        step();
        bus.wr = 1'b0;
        check("fp_dropped_not_full", bus.tx_full, 1'b0);
        bus.wr = 1'b1;
        bus.w_data = 8'hEF;
        step();
        bus.wr = 1'b0;
        check("fp_refill_full", bus.tx_full, 1'b1);
        exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'hEF};
        expect_frames("fp", 5);
        expect_silence("fp_after", FRAME);

        // Reset in the middle of bit 3 of 0x30 with two bytes queued.
        wq = '{8'h30, 8'h31, 8'h32};
        write_burst();
        wait_low(found);
        check("mid_fall", found, 1'b1);
        repeat (BIT / 2 + 4 * BIT) step();
        check("mid_bit3", tx, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_empty", bus.tx_empty, 1'b1);
        check("mid_rst_busy", bus.tx_busy, 1'b0);
        check("mid_rst_full", bus.tx_full, 1'b0);
        repeat (3) step();
        reset = 1'b1;
        step();
        expect_silence("mid_after", 3 * FRAME);
        check("mid_after_empty", bus.tx_empty, 1'b1);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
